// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: instruction-sequencing FSM with memory-wait handshaking.
// Datapath strobes are decoded combinationally from the current state, the latched opcode and memReady_i.
module multicycle_control #(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       memReady_i,
  output logic       pcWrite_o,
  output logic       pcWriteCond_o,
  output logic       iorD_o,
  output logic       memRead_o,
  output logic       memWrite_o,
  output logic       irWrite_o,
  output logic       memToReg_o,
  output logic       regDst_o,
  output logic       regWrite_o,
  output logic       aluSrcA_o,
  output logic [1:0] aluSrcB_o,
  output logic [1:0] pcSource_o,
  output logic [3:0] aluOp_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_XORI = 6'b001110;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       mem_rdy;

  // With waiting disabled every memory access is treated as completing at once.
  assign mem_rdy = (MEM_WAIT_EN != 0) ? memReady_i : 1'b1;
  assign state_o = state_q;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    pcWrite_o     = 1'b0;
    pcWriteCond_o = 1'b0;
    iorD_o        = 1'b0;
    memRead_o     = 1'b0;
    memWrite_o    = 1'b0;
    irWrite_o     = 1'b0;
    memToReg_o    = 1'b0;
    regDst_o      = 1'b0;
    regWrite_o    = 1'b0;
    aluSrcA_o     = 1'b0;
    aluSrcB_o     = 2'b00;
    pcSource_o    = 2'b00;
    aluOp_o       = 4'b0000;
    illegal_o     = 1'b0;

    case (state_q)
      S_FETCH: begin
        memRead_o = 1'b1;
        aluSrcB_o = 2'b01;
        irWrite_o = mem_rdy;
        pcWrite_o = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB_o = 2'b11;
        op_d      = opcode_i;
        case (opcode_i)
          OP_LW, OP_SW:                                state_d = S_MEMADR;
          OP_R:                                        state_d = S_REXEC;
          OP_BEQ:                                      state_d = S_BRANCH;
          OP_J:                                        state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI:  state_d = S_IEXEC;
          default: begin
            illegal_o = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA_o = 1'b1;
        aluSrcB_o = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memRead_o = 1'b1;
        iorD_o    = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memToReg_o = 1'b1;
        regWrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        memWrite_o = 1'b1;
        iorD_o     = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_REXEC: begin
        aluSrcA_o = 1'b1;
        aluOp_o   = 4'b0010;
        state_d   = S_RWB;
      end
      S_RWB: begin
        regDst_o   = 1'b1;
        regWrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA_o     = 1'b1;
        aluOp_o       = 4'b0001;
        pcWriteCond_o = 1'b1;
        pcSource_o    = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pcWrite_o  = 1'b1;
        pcSource_o = 2'b10;
        state_d    = S_FETCH;
      end
      S_IEXEC: begin
        aluSrcA_o = 1'b1;
        aluSrcB_o = 2'b10;
        case (op_q)
          OP_ADDI: aluOp_o = 4'b0011;
          OP_ANDI: aluOp_o = 4'b0100;
          OP_ORI:  aluOp_o = 4'b0101;
          OP_SLTI: aluOp_o = 4'b0110;
          OP_XORI: aluOp_o = 4'b0111;
          default: aluOp_o = 4'b0000;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        regWrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      // Unused codes recover to FETCH with every strobe left low.
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      op_q    <= 6'b000000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: one instance honouring memReady_i,
// one with memory waits disabled, both compared against hand-computed output vectors.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Strobe field order: pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg regDst regWrite aluSrcA
  localparam logic [9:0] PCW  = 10'b1000000000;
  localparam logic [9:0] PCWC = 10'b0100000000;
  localparam logic [9:0] IORD = 10'b0010000000;
  localparam logic [9:0] MRD  = 10'b0001000000;
  localparam logic [9:0] MWR  = 10'b0000100000;
  localparam logic [9:0] IRW  = 10'b0000010000;
  localparam logic [9:0] M2R  = 10'b0000001000;
  localparam logic [9:0] RDST = 10'b0000000100;
  localparam logic [9:0] RW   = 10'b0000000010;
  localparam logic [9:0] ASA  = 10'b0000000001;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic       memReady_i;

  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite, aluSrcA, illegal;
  logic [1:0] aluSrcB, pcSource;
  logic [3:0] aluOp, state;

  logic       nwPcWrite, nwPcWriteCond, nwIorD, nwMemRead, nwMemWrite, nwIrWrite, nwMemToReg, nwRegDst, nwRegWrite, nwAluSrcA, nwIllegal;
  logic [1:0] nwAluSrcB, nwPcSource;
  logic [3:0] nwAluOp, nwState;

  logic [22:0] obs, obsNw;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  multicycle_control dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .memReady_i(memReady_i),
    .pcWrite_o(pcWrite), .pcWriteCond_o(pcWriteCond), .iorD_o(iorD), .memRead_o(memRead),
    .memWrite_o(memWrite), .irWrite_o(irWrite), .memToReg_o(memToReg), .regDst_o(regDst),
    .regWrite_o(regWrite), .aluSrcA_o(aluSrcA), .aluSrcB_o(aluSrcB), .pcSource_o(pcSource),
    .aluOp_o(aluOp), .state_o(state), .illegal_o(illegal)
  );

  multicycle_control #(.MEM_WAIT_EN(0)) u_nw (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .memReady_i(1'b0),
    .pcWrite_o(nwPcWrite), .pcWriteCond_o(nwPcWriteCond), .iorD_o(nwIorD), .memRead_o(nwMemRead),
    .memWrite_o(nwMemWrite), .irWrite_o(nwIrWrite), .memToReg_o(nwMemToReg), .regDst_o(nwRegDst),
    .regWrite_o(nwRegWrite), .aluSrcA_o(nwAluSrcA), .aluSrcB_o(nwAluSrcB), .pcSource_o(nwPcSource),
    .aluOp_o(nwAluOp), .state_o(nwState), .illegal_o(nwIllegal)
  );

  assign obs = {state, pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst,
                regWrite, aluSrcA, aluSrcB, pcSource, aluOp, illegal};
  assign obsNw = {nwState, nwPcWrite, nwPcWriteCond, nwIorD, nwMemRead, nwMemWrite, nwIrWrite,
                  nwMemToReg, nwRegDst, nwRegWrite, nwAluSrcA, nwAluSrcB, nwPcSource, nwAluOp, nwIllegal};

  function automatic logic [22:0] mk(input logic [3:0] st, input logic [9:0] sb, input logic [1:0] srcB,
                                     input logic [1:0] pcSrc, input logic [3:0] aop, input logic ill);
    return {st, sb, srcB, pcSrc, aop, ill};
  endfunction

  // Drive inputs just after a rising edge and let combinational outputs settle.
  task automatic applyStimulus(input logic [5:0] op, input logic rdy);
    opcode_i   = op;
    memReady_i = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [22:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkNoWait(input string tag, input logic [22:0] exp);
    vectors++;
    assert (obsNw === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obsNw, exp);
    end
  endtask

  logic [22:0] eF1, eF0, eDec, eMemAdr;
  logic [5:0]  iOps  [5];
  logic [3:0]  iAops [5];

  initial begin
    eF1     = mk(4'd0, MRD | IRW | PCW, 2'b01, 2'b00, 4'b0000, 1'b0);
    eF0     = mk(4'd0, MRD, 2'b01, 2'b00, 4'b0000, 1'b0);
    eDec    = mk(4'd1, 10'b0, 2'b11, 2'b00, 4'b0000, 1'b0);
    eMemAdr = mk(4'd2, ASA, 2'b10, 2'b00, 4'b0000, 1'b0);
    iOps[0] = 6'b001000; iAops[0] = 4'b0011;
    iOps[1] = 6'b001100; iAops[1] = 4'b0100;
    iOps[2] = 6'b001101; iAops[2] = 4'b0101;
    iOps[3] = 6'b001010; iAops[3] = 4'b0110;
    iOps[4] = 6'b001110; iAops[4] = 4'b0111;

    rst_i = 1'b1;
    applyStimulus(OP_LW, 1'b0);
    checkOutput("reset_rdy0", eF0);
    applyStimulus(OP_LW, 1'b1);
    checkOutput("reset_rdy1", eF1);
    tick();
    checkOutput("reset_held_over_edge", eF1);
    rst_i = 1'b0;
    #1;

    // lw on both instances; opcode changes after DECODE to prove opReg is used.
    checkOutput("lw_fetch", eF1);
    checkNoWait("nw_fetch", eF1);
    tick();
    checkOutput("lw_decode", eDec);
    checkNoWait("nw_decode", eDec);
    tick();
    applyStimulus(OP_SW, 1'b1);
    checkOutput("lw_memadr", eMemAdr);
    checkNoWait("nw_memadr", eMemAdr);
    tick();
    checkOutput("lw_memrd", mk(4'd3, MRD | IORD, 2'b00, 2'b00, 4'b0000, 1'b0));
    checkNoWait("nw_memrd_no_wait", mk(4'd3, MRD | IORD, 2'b00, 2'b00, 4'b0000, 1'b0));
    tick();
    checkOutput("lw_memwb", mk(4'd4, M2R | RW, 2'b00, 2'b00, 4'b0000, 1'b0));
    checkNoWait("nw_memwb", mk(4'd4, M2R | RW, 2'b00, 2'b00, 4'b0000, 1'b0));
    tick();
    checkOutput("lw_done", eF1);
    checkNoWait("nw_done", eF1);

    // FETCH stall, then an R-type instruction.
    applyStimulus(OP_R, 1'b0);
    checkOutput("fetch_stall_0", eF0);
    tick();
    checkOutput("fetch_stall_1", eF0);
    tick();
    applyStimulus(OP_R, 1'b1);
    checkOutput("r_fetch", eF1);
    tick();
    checkOutput("r_decode", eDec);
    tick();
    checkOutput("r_rexec", mk(4'd6, ASA, 2'b00, 2'b00, 4'b0010, 1'b0));
    tick();
    checkOutput("r_rwb", mk(4'd7, RDST | RW, 2'b00, 2'b00, 4'b0000, 1'b0));
    tick();
    checkOutput("r_done", eF1);

    // sw with memReady low for three MEMWR cycles.
    applyStimulus(OP_SW, 1'b1);
    tick();
    checkOutput("sw_decode", eDec);
    tick();
    applyStimulus(OP_LW, 1'b0);
    checkOutput("sw_memadr", eMemAdr);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("sw_memwr_wait", mk(4'd5, MWR | IORD, 2'b00, 2'b00, 4'b0000, 1'b0));
      tick();
    end
    applyStimulus(OP_LW, 1'b1);
    checkOutput("sw_memwr_last", mk(4'd5, MWR | IORD, 2'b00, 2'b00, 4'b0000, 1'b0));
    tick();
    checkOutput("sw_done", eF1);

    applyStimulus(OP_BEQ, 1'b1);
    tick();
    checkOutput("beq_decode", eDec);
    tick();
    checkOutput("beq_branch", mk(4'd8, ASA | PCWC, 2'b00, 2'b01, 4'b0001, 1'b0));
    tick();
    checkOutput("beq_done", eF1);

    applyStimulus(OP_J, 1'b1);
    tick();
    tick();
    checkOutput("j_jump", mk(4'd9, PCW, 2'b00, 2'b10, 4'b0000, 1'b0));
    tick();
    checkOutput("j_done", eF1);

    applyStimulus(OP_BAD, 1'b1);
    tick();
    checkOutput("illegal_decode", mk(4'd1, 10'b0, 2'b11, 2'b00, 4'b0000, 1'b1));
    tick();
    checkOutput("illegal_done", eF1);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(iOps[k], 1'b1);
      tick();
      checkOutput("itype_decode", eDec);
      tick();
      applyStimulus(OP_R, 1'b1);
      checkOutput("itype_iexec", mk(4'd10, ASA, 2'b10, 2'b00, iAops[k], 1'b0));
      tick();
      checkOutput("itype_iwb", mk(4'd11, RW, 2'b00, 2'b00, 4'b0000, 1'b0));
      tick();
      checkOutput("itype_done", eF1);
    end

    // Asynchronous reset in the middle of MEMRD.
    applyStimulus(OP_LW, 1'b1);
    tick();
    tick();
    tick();
    applyStimulus(OP_LW, 1'b0);
    checkOutput("rst_memrd_before", mk(4'd3, MRD | IORD, 2'b00, 2'b00, 4'b0000, 1'b0));
    #2 rst_i = 1'b1;
    #1;
    checkOutput("rst_memrd_async", eF0);
    vectors++;
    assert (dut.op_q === 6'b000000) else begin
      miscompares++;
      $error("[TB] FAIL rst_opreg: observed %b expected %b", dut.op_q, 6'b000000);
    end
    #1 rst_i = 1'b0;
    tick();
    checkOutput("rst_memrd_after", eF0);

    // Reset aborting a store: no write strobe afterwards.
    applyStimulus(OP_SW, 1'b1);
    tick();
    tick();
    tick();
    applyStimulus(OP_SW, 1'b0);
    checkOutput("rst_memwr_before", mk(4'd5, MWR | IORD, 2'b00, 2'b00, 4'b0000, 1'b0));
    #2 rst_i = 1'b1;
    #1;
    checkOutput("rst_memwr_async", eF0);
    #1 rst_i = 1'b0;
    applyStimulus(OP_BAD, 1'b1);
    checkOutput("rst_memwr_fetch", eF1);
    tick();
    checkOutput("rst_memwr_decode", mk(4'd1, 10'b0, 2'b11, 2'b00, 4'b0000, 1'b1));
    tick();
    checkOutput("rst_memwr_done", eF1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
